rr_arb8: RTL

Eight-input round-robin request arbiter that feeds the 8-to-3 encoder stage.

- Latches pulsed request lines into a pending register.
- Selects one pending requester per grant, in rotating priority.
- Presents the selection as a registered one-hot grant with a valid/ready handshake.
- Guarantees the downstream encoder only ever sees a legal one-hot word (or all-zero) on its input.

---
 rtl/rr_arb8_pkg.sv | 27 ++
 rtl/rr_pick8.sv | 44 ++++
 rtl/rr_arb8.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rr_arb8_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb8_pkg
// Shared constants, FSM state type and a one-hot encode helper for the
// eight-input round-robin arbiter (rr_arb8) and its picker (rr_pick8).
// -----------------------------------------------------------------------------
package rr_arb8_pkg;

  localparam int N     = 8;  // number of requesters / one-hot grant width
  localparam int IDX_W = 3;  // encoded index width, log2(N)

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Binary index of a one-hot word. OR-reduction is exact for legal one-hot
  // input and yields 0 for an all-zero word.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx = idx | (oh[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
// Combinational rotating-priority picker: returns the first set bit of
// `pending` at index >= `ptr`, scanning upward and wrapping 7 -> 0.
//
// Ports:
//   pending [7:0]  in   pending request vector
//   ptr     [2:0]  in   highest-priority index for this scan
//   onehot  [7:0]  out  one-hot of the selected requester (0 when none)
//   idx     [2:0]  out  binary index of the selected requester (0 when none)
//   any            out  at least one request is pending
// -----------------------------------------------------------------------------
module rr_pick8
  import rr_arb8_pkg::*;
(
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] w_pos;

  // Scan from ptr with 3-bit wrap; only the first hit is kept, so onehot
  // can never carry more than one set bit.
  always_comb begin
    onehot = {N{1'b0}};
    idx    = {IDX_W{1'b0}};
    any    = 1'b0;
    w_pos  = {IDX_W{1'b0}};
    for (int k = 0; k < N; k++) begin
      w_pos = ptr + IDX_W'(k);
      if (!any && pending[w_pos]) begin
        any    = 1'b1;
        idx    = w_pos;
        onehot = {{(N-1){1'b0}}, 1'b1} << w_pos;
      end else begin
        any    = any;
      end
    end
  end

endmodule

// File: rtl/rr_arb8.sv
// -----------------------------------------------------------------------------
// rr_arb8
// Eight-input round-robin request arbiter feeding the 8-to-3 encoder stage.
// Request pulses accumulate in a pending register; one pending requester is
// granted at a time in rotating priority, presented as a registered one-hot
// word with a valid/ready handshake. gnt_out is always legal one-hot or zero.
//
// Build option: define RR_ARB8_IDX_OUT_EN to add the registered gnt_idx port.
//
// Ports:
//   clk              in   rising-edge clock
//   rst              in   asynchronous active-high reset
//   en               in   arbitration enable (blocks new grants only)
//   req_in    [7:0]  in   request pulses, bit i for requester i
//   gnt_ready        in   downstream accepts the current grant
//   gnt_out   [7:0]  out  registered one-hot grant, zero when not valid
//   gnt_valid        out  gnt_out holds a valid grant
//   pending   [7:0]  out  pending-request register
//   gnt_idx   [2:0]  out  encoded index of gnt_out (RR_ARB8_IDX_OUT_EN only)
// -----------------------------------------------------------------------------
module rr_arb8
  import rr_arb8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req_in,
  input  logic             gnt_ready,
  output logic [N-1:0]     gnt_out,
  output logic             gnt_valid,
  output logic [N-1:0]     pending
`ifdef RR_ARB8_IDX_OUT_EN
  ,
  output logic [IDX_W-1:0] gnt_idx
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_pending;
  logic [N-1:0]     w_pending_nxt;
  logic [N-1:0]     w_clr;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [N-1:0]     r_gnt_out;
  logic [N-1:0]     w_gnt_nxt;
  logic             r_gnt_valid;
  logic             w_valid_nxt;
  logic [N-1:0]     w_pick_onehot;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_any;
`ifdef RR_ARB8_IDX_OUT_EN
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] w_idx_nxt;
`else
  logic             w_unused_idx;
  assign w_unused_idx = ^w_pick_idx;
`endif

  rr_pick8 u_pick (
    .pending (r_pending),
    .ptr     (r_ptr),
    .onehot  (w_pick_onehot),
    .idx     (w_pick_idx),
    .any     (w_pick_any)
  );

  // Pending update: the handshaken bit is cleared, but a request arriving
  // on that same edge wins and keeps the bit pending.
  always_comb begin
    w_clr         = (r_gnt_valid && gnt_ready) ? r_gnt_out : {N{1'b0}};
    w_pending_nxt = (r_pending & ~w_clr) | req_in;
  end

  // Next-state and next-output logic of the grant FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt_out;
    w_valid_nxt = r_gnt_valid;
    w_ptr_nxt   = r_ptr;
`ifdef RR_ARB8_IDX_OUT_EN
    w_idx_nxt   = r_gnt_idx;
`endif
    case (r_state)
      IDLE: begin
        if (en && w_pick_any) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_pick_onehot;
          w_valid_nxt = 1'b1;
`ifdef RR_ARB8_IDX_OUT_EN
          w_idx_nxt   = w_pick_idx;
`endif
        end else begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = {N{1'b0}};
          w_valid_nxt = 1'b0;
`ifdef RR_ARB8_IDX_OUT_EN
          w_idx_nxt   = {IDX_W{1'b0}};
`endif
        end
      end
      GRANT: begin
        // en is ignored here: an issued grant is held until accepted.
        if (gnt_ready) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = {N{1'b0}};
          w_valid_nxt = 1'b0;
          // Rotate priority past the requester just served (7 wraps to 0).
          w_ptr_nxt   = onehot_to_idx(r_gnt_out) + 3'd1;
`ifdef RR_ARB8_IDX_OUT_EN
          w_idx_nxt   = {IDX_W{1'b0}};
`endif
        end else begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = r_gnt_out;
          w_valid_nxt = r_gnt_valid;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = {N{1'b0}};
        w_valid_nxt = 1'b0;
`ifdef RR_ARB8_IDX_OUT_EN
        w_idx_nxt   = {IDX_W{1'b0}};
`endif
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending, priority pointer and grant output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= {N{1'b0}};
      r_ptr       <= {IDX_W{1'b0}};
      r_gnt_out   <= {N{1'b0}};
      r_gnt_valid <= 1'b0;
`ifdef RR_ARB8_IDX_OUT_EN
      r_gnt_idx   <= {IDX_W{1'b0}};
`endif
    end else begin
      r_pending   <= w_pending_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt_out   <= w_gnt_nxt;
      r_gnt_valid <= w_valid_nxt;
`ifdef RR_ARB8_IDX_OUT_EN
      r_gnt_idx   <= w_idx_nxt;
`endif
    end
  end

  assign gnt_out   = r_gnt_out;
  assign gnt_valid = r_gnt_valid;
  assign pending   = r_pending;
`ifdef RR_ARB8_IDX_OUT_EN
  assign gnt_idx   = r_gnt_idx;
`endif

endmodule
